// File: rtl/prog_counter_gen.sv
// Programmable up/down counter with WRAP, ONESHOT and RELOAD endpoint behaviour and a runtime limit.
// Latency: one cycle from any input to every registered output. There is no backpressure; an input is acted on in the cycle it is sampled.
module prog_counter_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LIMIT_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             limit_wr,
  input  logic [WIDTH-1:0] limit_val,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] limit,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    COUNTING = 1'b0,
    HALTED   = 1'b1
  } state_e;

  localparam logic [1:0]       MODE_ONESHOT = 2'b01;
  localparam logic [1:0]       MODE_RELOAD  = 2'b10;
  localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             at_end;
  logic             step_en;

  // Up-count uses >= so that a limit lowered below the count still terminates.
  assign at_end  = up_dn ? (count_q >= limit_q) : (count_q == '0);
  assign step_en = ena && !load && (state_q == COUNTING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COUNTING;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load || (state_q == HALTED && mode != MODE_ONESHOT)) begin
      state_d = COUNTING;
    end else if (step_en && at_end && mode == MODE_ONESHOT) begin
      state_d = HALTED;
    end
  end

  always_comb begin
    done = (state_q == HALTED);
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    limit_d  = limit_write_value();
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
    end else if (step_en) begin
      if (at_end) begin
        tc_d = 1'b1;
        case (mode)
          MODE_ONESHOT: count_d = count_q;
          MODE_RELOAD:  count_d = reload_q;
          default:      count_d = up_dn ? '0 : limit_q;
        endcase
      end else begin
        count_d = up_dn ? (count_q + ONE) : (count_q - ONE);
      end
    end
  end

  function automatic logic [WIDTH-1:0] limit_write_value();
    return limit_wr ? limit_val : limit_q;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      limit_q  <= LIMIT_RST;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign limit = limit_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_prog_counter_gen.sv
// Directed bench for prog_counter_gen at WIDTH = 8: each scenario task drives vectors and checks hand-computed values.
module tb_prog_counter_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       load;
  logic [7:0] load_val;
  logic       limit_wr;
  logic [7:0] limit_val;
  logic       up_dn;
  logic [1:0] mode;
  logic [7:0] count;
  logic [7:0] limit;
  logic       tc;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  prog_counter_gen #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .load      (load),
    .load_val  (load_val),
    .limit_wr  (limit_wr),
    .limit_val (limit_val),
    .up_dn     (up_dn),
    .mode      (mode),
    .count     (count),
    .limit     (limit),
    .tc        (tc),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; load = 1'b0; limit_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; load = 1'b0; load_val = 8'd0;
    limit_wr = 1'b0; limit_val = 8'd0; up_dn = 1'b1; mode = 2'b00;
    step(); step();
    n_tests++; if (count !== 8'd0)   begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_tests++; if (limit !== 8'd255) begin n_fail++; $display("FAIL reset_limit got %0d want 255", limit); end
    n_tests++; if (tc !== 1'b0)      begin n_fail++; $display("FAIL reset_tc got %b want 0", tc); end
    n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    step();
    n_tests++; if (count !== 8'd0)   begin n_fail++; $display("FAIL reset_release_hold got %0d want 0", count); end
  endtask

  task automatic test_wrap_up();
    logic [7:0] exp_c [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    logic       exp_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'b00; up_dn = 1'b1; ena = 1'b1; limit_wr = 1'b1; limit_val = 8'd5;
    for (int i = 0; i < 7; i++) begin
      step();
      limit_wr = 1'b0;
      n_tests++; if (count !== exp_c[i]) begin n_fail++; $display("FAIL wrap_up_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_tests++; if (tc !== exp_t[i])    begin n_fail++; $display("FAIL wrap_up_tc[%0d] got %b want %b", i, tc, exp_t[i]); end
    end
    n_tests++; if (limit !== 8'd5) begin n_fail++; $display("FAIL wrap_up_limit got %0d want 5", limit); end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd5, 8'd4};
    logic       exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    mode = 2'b11; load = 1'b1; load_val = 8'd2; ena = 1'b0;
    step();
    load = 1'b0;
    n_tests++; if (count !== 8'd2) begin n_fail++; $display("FAIL wrap_dn_load got %0d want 2", count); end
    up_dn = 1'b0; ena = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++; if (count !== exp_c[i]) begin n_fail++; $display("FAIL wrap_dn_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_tests++; if (tc !== exp_t[i])    begin n_fail++; $display("FAIL wrap_dn_tc[%0d] got %b want %b", i, tc, exp_t[i]); end
    end
    ena = 1'b0;
    step();
    n_tests++; if (count !== 8'd4 || tc !== 1'b0) begin n_fail++; $display("FAIL wrap_dn_hold got %0d/%b want 4/0", count, tc); end
    idle_inputs();
  endtask

  task automatic test_reload_up();
    logic [7:0] exp_c [6] = '{8'd8, 8'd9, 8'd7, 8'd8, 8'd9, 8'd7};
    logic       exp_t [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    mode = 2'b10; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd7; limit_wr = 1'b1; limit_val = 8'd9;
    step();
    idle_inputs();
    n_tests++; if (count !== 8'd7 || limit !== 8'd9) begin n_fail++; $display("FAIL reload_setup got %0d/%0d want 7/9", count, limit); end
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (count !== exp_c[i]) begin n_fail++; $display("FAIL reload_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_tests++; if (tc !== exp_t[i])    begin n_fail++; $display("FAIL reload_tc[%0d] got %b want %b", i, tc, exp_t[i]); end
    end
    idle_inputs();
  endtask

  task automatic test_oneshot();
    logic [7:0] exp_c [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3};
    logic       exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_d [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mode = 2'b01; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd0; limit_wr = 1'b1; limit_val = 8'd3;
    step();
    idle_inputs();
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++; if (count !== exp_c[i]) begin n_fail++; $display("FAIL oneshot_count[%0d] got %0d want %0d", i, count, exp_c[i]); end
      n_tests++; if (tc !== exp_t[i])    begin n_fail++; $display("FAIL oneshot_tc[%0d] got %b want %b", i, tc, exp_t[i]); end
      n_tests++; if (done !== exp_d[i])  begin n_fail++; $display("FAIL oneshot_done[%0d] got %b want %b", i, done, exp_d[i]); end
    end
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    n_tests++; if (count !== 8'd0 || done !== 1'b0 || tc !== 1'b0) begin n_fail++; $display("FAIL oneshot_reload got %0d/%b/%b want 0/0/0", count, done, tc); end
    step();
    n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL oneshot_resume got %0d want 1", count); end
    step(); step(); step();
    n_tests++; if (done !== 1'b1 || count !== 8'd3) begin n_fail++; $display("FAIL oneshot_redone got %0d/%b want 3/1", count, done); end
    // Leaving ONESHOT: that edge only releases HALTED, the next one wraps.
    mode = 2'b00;
    step();
    n_tests++; if (done !== 1'b0 || count !== 8'd3 || tc !== 1'b0) begin n_fail++; $display("FAIL oneshot_exit got %0d/%b/%b want 3/0/0", count, done, tc); end
    step();
    n_tests++; if (count !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL oneshot_exit_wrap got %0d/%b want 0/1", count, tc); end
    idle_inputs();
  endtask

  task automatic test_limit_change();
    mode = 2'b00; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd200; limit_wr = 1'b1; limit_val = 8'd255;
    step();
    load = 1'b0;
    ena = 1'b1; limit_wr = 1'b1; limit_val = 8'd50;
    step();
    limit_wr = 1'b0;
    n_tests++; if (count !== 8'd201 || tc !== 1'b0) begin n_fail++; $display("FAIL limchg_old got %0d/%b want 201/0", count, tc); end
    n_tests++; if (limit !== 8'd50) begin n_fail++; $display("FAIL limchg_limit got %0d want 50", limit); end
    step();
    n_tests++; if (count !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL limchg_term got %0d/%b want 0/1", count, tc); end
    idle_inputs();
    load = 1'b1; load_val = 8'd100;
    step();
    load = 1'b0; ena = 1'b1; up_dn = 1'b0;
    step();
    n_tests++; if (count !== 8'd99 || tc !== 1'b0) begin n_fail++; $display("FAIL limchg_down got %0d/%b want 99/0", count, tc); end
    idle_inputs();
  endtask

  task automatic test_load_priority();
    mode = 2'b00; up_dn = 1'b1;
    load = 1'b1; load_val = 8'd255; limit_wr = 1'b1; limit_val = 8'd255;
    step();
    limit_wr = 1'b0;
    load = 1'b1; load_val = 8'd17; ena = 1'b1;
    step();
    load = 1'b0;
    n_tests++; if (count !== 8'd17 || tc !== 1'b0) begin n_fail++; $display("FAIL loadprio got %0d/%b want 17/0", count, tc); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    // Down-count from 0 with limit 100 so the reset lands during a tc pulse.
    mode = 2'b00; up_dn = 1'b0;
    load = 1'b1; load_val = 8'd0; limit_wr = 1'b1; limit_val = 8'd100;
    step();
    idle_inputs();
    ena = 1'b1;
    step();
    n_tests++; if (count !== 8'd100 || tc !== 1'b1) begin n_fail++; $display("FAIL arst_pre got %0d/%b want 100/1", count, tc); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (count !== 8'd0)   begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
    n_tests++; if (tc !== 1'b0)      begin n_fail++; $display("FAIL arst_tc got %b want 0", tc); end
    n_tests++; if (limit !== 8'd255) begin n_fail++; $display("FAIL arst_limit got %0d want 255", limit); end
    step();
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL arst_held got %0d want 0", count); end
    #2 rst_n = 1'b1;
    up_dn = 1'b1;
    step();
    n_tests++; if (count !== 8'd1) begin n_fail++; $display("FAIL arst_first_step got %0d want 1", count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_reload_up();
    test_oneshot();
    test_limit_change();
    test_load_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_counter_gen.md
PROG_COUNTER_GEN -- requirements
Module: prog_counter_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/limit/load width in bits (>=2).
REQ-002 SHALL have parameter LIMIT_RST, default {WIDTH{1'b1}}, reset value of limit register.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ena  input  1  count step enable, one step per enabled cycle.
REQ-006 SHALL have port load  input  1  synchronous load of count from load_val.
REQ-007 SHALL have port load_val  input  WIDTH  load value; also captured as reload value.
REQ-008 SHALL have port limit_wr  input  1  synchronous write of limit register.
REQ-009 SHALL have port limit_val  input  WIDTH  new limit value.
REQ-010 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down; sampled every cycle.
REQ-011 SHALL have port mode  input  2  00 WRAP, 01 ONESHOT, 10 RELOAD, 11 treated as WRAP.
REQ-012 SHALL have port count  output  WIDTH  registered count value.
REQ-013 SHALL have port limit  output  WIDTH  registered limit register value.
REQ-014 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-015 SHALL have port done  output  1  registered ONESHOT completion flag.

Function
REQ-016 Endpoint SHALL be: up -> count >= limit; down -> count == 0.
REQ-017 Per-edge priority SHALL be: load, then ena step; limit_wr is independent and applies in parallel.
REQ-018 load SHALL set count = load_val, reload_reg = load_val, done = 0, tc = 0 next cycle, regardless of ena.
REQ-019 Enabled step not at endpoint SHALL move count by +1 (up) or -1 (down), tc = 0.
REQ-020 Terminal event = enabled step (no load) with count at endpoint and done == 0.
REQ-021 WRAP terminal event: count <= 0 (up) or count <= limit (down).
REQ-022 RELOAD terminal event: count <= reload_reg, either direction.
REQ-023 ONESHOT terminal event: count holds, done <= 1; while done == 1 steps SHALL be ignored, no tc.
REQ-024 tc SHALL be 1 for exactly the one cycle after each terminal event, else 0.
REQ-025 ena == 0 and load == 0: count, done hold; tc = 0.
REQ-026 limit_wr SHALL update limit next cycle; a step in the same cycle uses the old limit.
REQ-027 If count > limit after a limit write, the next up step SHALL be a terminal event; down steps decrement normally.
REQ-028 done SHALL clear to 0 on the edge after mode != ONESHOT is sampled, or on load.
REQ-029 All arithmetic SHALL be modulo 2^WIDTH; no carry out beyond WIDTH.
REQ-030 up_dn and mode changes SHALL take effect on the same edge they are sampled, without extra latency.
REQ-031 Implementation SHALL use a two-state control FSM, COUNTING/HALTED; HALTED is entered only via REQ-023 and exited per REQ-028.

Reset
REQ-032 rst_n low SHALL asynchronously force count = 0, limit = LIMIT_RST, reload_reg = 0, tc = 0, done = 0, FSM = COUNTING.
REQ-033 Reset deassertion SHALL be sampled synchronously; first step occurs no earlier than the first clock edge with rst_n high.
REQ-034 Reset asserted mid-count or mid-tc pulse SHALL abort immediately to REQ-032 values.

Verification (WIDTH = 8)
REQ-035 WRAP up, limit_wr 5, ena held from 0 -> count 0,1,2,3,4,5,0; tc high only the cycle count returns to 0.
REQ-036 WRAP down, limit 5, load 2, ena held -> count 2,1,0,5,4; one tc pulse with count = 5.
REQ-037 RELOAD up, limit 9, load 7, ena held -> 7,8,9,7,8,9; tc pulse each return to 7.
REQ-038 ONESHOT up, limit 3, from 0 -> 0,1,2,3,3,3; single tc, done = 1 and held; load 0 -> done = 0, counting resumes.
REQ-039 count = 200, limit_wr 50 with ena, up -> step uses old limit (201), next step terminal, count = 0 (WRAP), tc = 1.
REQ-040 load and ena together at count = 255, limit 255 -> count = load_val, tc = 0; rst_n low mid-sequence -> all outputs reset same cycle.
